// File: rtl/car_direction_fsm.sv
// Direction decoder for the parking-lot counter: tracks the four-phase beam
// pattern (outer a, inner b) and emits one-cycle inc/dec/abort pulses.
module car_direction_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic abort,
    output logic busy,
    output logic fault
);

    localparam logic [3:0] ARM        = 4'd0;
    localparam logic [3:0] IDLE       = 4'd1;
    localparam logic [3:0] ENT1       = 4'd2;
    localparam logic [3:0] ENT2       = 4'd3;
    localparam logic [3:0] ENT3       = 4'd4;
    localparam logic [3:0] EXT1       = 4'd5;
    localparam logic [3:0] EXT2       = 4'd6;
    localparam logic [3:0] EXT3       = 4'd7;
    localparam logic [3:0] WAIT_CLEAR = 4'd8;

    logic [3:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               inc_q, inc_d;
    logic               dec_q, dec_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic [1:0]         ab;
    logic               hold;
    logic               bad;

    always_comb begin
        ab      = {a, b};
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        abort_d = 1'b0;
        hold    = 1'b0;
        bad     = 1'b0;

        case (state_q)
            ARM: begin
                if (ab == 2'b00) state_d = IDLE;
            end
            IDLE: begin
                case (ab)
                    2'b10:   state_d = ENT1;
                    2'b01:   state_d = EXT1;
                    2'b11:   bad     = 1'b1;
                    default: ;
                endcase
            end
            ENT1: begin
                case (ab)
                    2'b11:   state_d = ENT2;
                    2'b00:   state_d = IDLE;
                    2'b01:   bad     = 1'b1;
                    default: hold    = 1'b1;
                endcase
            end
            ENT2: begin
                case (ab)
                    2'b01:   state_d = ENT3;
                    2'b10:   state_d = ENT1;
                    2'b00:   bad     = 1'b1;
                    default: hold    = 1'b1;
                endcase
            end
            ENT3: begin
                case (ab)
                    2'b00: begin
                        state_d = IDLE;
                        inc_d   = 1'b1;
                    end
                    2'b11:   state_d = ENT2;
                    2'b10:   bad     = 1'b1;
                    default: hold    = 1'b1;
                endcase
            end
            EXT1: begin
                case (ab)
                    2'b11:   state_d = EXT2;
                    2'b00:   state_d = IDLE;
                    2'b10:   bad     = 1'b1;
                    default: hold    = 1'b1;
                endcase
            end
            EXT2: begin
                case (ab)
                    2'b10:   state_d = EXT3;
                    2'b01:   state_d = EXT1;
                    2'b00:   bad     = 1'b1;
                    default: hold    = 1'b1;
                endcase
            end
            EXT3: begin
                case (ab)
                    2'b00: begin
                        state_d = IDLE;
                        dec_d   = 1'b1;
                    end
                    2'b11:   state_d = EXT2;
                    2'b01:   bad     = 1'b1;
                    default: hold    = 1'b1;
                endcase
            end
            WAIT_CLEAR: begin
                if (ab == 2'b00) state_d = IDLE;
            end
            default: state_d = ARM;
        endcase

        // A stalled mid-sequence state is treated exactly like an illegal step.
        if (bad || (hold && timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
            abort_d = 1'b1;
            state_d = WAIT_CLEAR;
        end

        timer_d = (hold && state_d == state_q) ? timer_q + TIMER_W'(1) : '0;
        busy_d  = (state_d >= ENT1) && (state_d <= EXT3);
        fault_d = (state_d == WAIT_CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
            timer_q <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign inc   = inc_q;
    assign dec   = dec_q;
    assign abort = abort_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_car_direction_fsm.sv
// Scoreboard bench for car_direction_fsm: stimulus pushes expected pulses with
// their cycle number, a negedge monitor pops and compares them.
module tb_car_direction_fsm;

    localparam int K_INC   = 1;
    localparam int K_DEC   = 2;
    localparam int K_ABORT = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic inc, dec, abort, busy, fault;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t expq[$];

    car_direction_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .a     (a),
        .b     (b),
        .inc   (inc),
        .dec   (dec),
        .abort (abort),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected pulse appears after the next rising edge, i.e. at cycle cyc+1.
    task automatic expect_pulse(input int kind, input int delay);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + 1 + delay;
        expq.push_back(e);
    endtask

    task automatic step(input logic [1:0] v, input int n);
        a = v[1];
        b = v[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic full_entry();
        step(2'b10, 3);
        chk("entry_busy_10", int'(busy), 1);
        step(2'b11, 3);
        step(2'b01, 3);
        chk("entry_busy_01", int'(busy), 1);
        expect_pulse(K_INC, 0);
        step(2'b00, 3);
        chk("entry_busy_end", int'(busy), 0);
    endtask

    always @(negedge clk) begin : monitor
        int   k;
        exp_t e;
        if (inc || dec || abort) begin
            k = inc ? K_INC : (dec ? K_DEC : K_ABORT);
            chk("pulse_exclusive", int'(inc) + int'(dec) + int'(abort), 1);
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", k, cyc);
            end else begin
                e = expq.pop_front();
                chk("pulse_kind", k, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_inc", int'(inc), 0);
        chk("reset_dec", int'(dec), 0);
        chk("reset_abort", int'(abort), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fault", int'(fault), 0);
        rst_n = 1'b1;
        step(2'b00, 3);

        // Clean entry
        full_entry();

        // Exit
        step(2'b01, 3);
        chk("exit_busy", int'(busy), 1);
        step(2'b11, 3);
        step(2'b10, 3);
        expect_pulse(K_DEC, 0);
        step(2'b00, 3);
        chk("exit_busy_end", int'(busy), 0);

        // Entry with a backup
        step(2'b10, 3);
        step(2'b11, 3);
        step(2'b10, 3);
        chk("backup_busy", int'(busy), 1);
        step(2'b11, 3);
        step(2'b01, 3);
        expect_pulse(K_INC, 0);
        step(2'b00, 3);

        // Balk
        step(2'b10, 3);
        chk("balk_busy", int'(busy), 1);
        step(2'b00, 3);
        chk("balk_busy_end", int'(busy), 0);
        chk("balk_fault", int'(fault), 0);

        // Illegal jump
        expect_pulse(K_ABORT, 0);
        step(2'b11, 3);
        chk("illegal_fault", int'(fault), 1);
        chk("illegal_busy", int'(busy), 0);
        step(2'b01, 3);
        chk("illegal_fault_hold", int'(fault), 1);
        step(2'b00, 3);
        chk("illegal_fault_clear", int'(fault), 0);
        full_entry();

        // Timeout: ENT1 entered at next edge, abort 16 edges later
        expect_pulse(K_ABORT, 16);
        step(2'b10, 40);
        chk("timeout_fault", int'(fault), 1);
        chk("timeout_busy", int'(busy), 0);
        step(2'b00, 3);
        chk("timeout_fault_clear", int'(fault), 0);

        // Reset in ENT2
        step(2'b10, 3);
        step(2'b11, 3);
        chk("ent2_busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        a = 1'b0;
        b = 1'b1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_fault", int'(fault), 0);
        chk("async_pulses", int'(inc) + int'(dec) + int'(abort), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 3);
        chk("arm_busy", int'(busy), 0);
        step(2'b11, 3);
        chk("arm_busy_11", int'(busy), 0);
        step(2'b00, 3);
        full_entry();

        step(2'b00, 5);
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
